// File: rtl/gate_half_adder_unit_if.sv
// gate_half_adder_unit_if: operand/result handshake bundle for gate_half_adder_unit.
// Revision: 1.0
`default_nettype none

interface gate_half_adder_unit_if #(
  parameter int WIDTH = 1
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] c;
  logic             cout;

  // Producer of operands, consumer of results.
  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, s, c, cout
  );

  // The arithmetic unit itself.
  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, s, c, cout
  );
endinterface

`default_nettype wire

// File: rtl/gate_half_adder_unit.sv
// gate_half_adder_unit: registered half adder (mode 0) / ripple-carry adder (mode 1) with valid/ready handshake.
// Revision: 1.0
`default_nettype none

module gate_half_adder_unit #(
  parameter int WIDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  gate_half_adder_unit_if.slave bus
);

  logic [WIDTH-1:0] ha_sum;
  logic [WIDTH-1:0] ha_carry;
  logic [WIDTH-1:0] rip_sum;
  logic [WIDTH-1:0] rip_carry;
  logic [WIDTH-1:0] res_s;
  logic [WIDTH-1:0] res_c;
  logic             res_cout;
  logic             accept;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] s_d, s_q;
  logic [WIDTH-1:0] c_d, c_q;
  logic             cout_d, cout_q;

  // First level: one XOR/AND gate pair per bit, shared by both modes.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_half_adder
      assign ha_sum[i]   = bus.a[i] ^ bus.b[i];
      assign ha_carry[i] = bus.a[i] & bus.b[i];
    end
  endgenerate

  always_comb begin
    logic cin;
    rip_sum   = '0;
    rip_carry = '0;
    cin       = 1'b0;
    for (int k = 0; k < WIDTH; k++) begin
      rip_sum[k]   = ha_sum[k] ^ cin;
      rip_carry[k] = ha_carry[k] | (ha_sum[k] & cin);
      cin          = rip_carry[k];
    end
  end

  always_comb begin
    res_s    = ha_sum;
    res_c    = ha_carry;
    res_cout = |ha_carry;
    if (bus.mode) begin
      res_s    = rip_sum;
      res_c    = rip_carry;
      res_cout = rip_carry[WIDTH-1];
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  // Results are kept after consumption; only out_valid drops.
  always_comb begin
    out_valid_d = out_valid_q;
    s_d         = s_q;
    c_d         = c_q;
    cout_d      = cout_q;
    if (accept) begin
      out_valid_d = 1'b1;
      s_d         = res_s;
      c_d         = res_c;
      cout_d      = res_cout;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      s_q         <= '0;
      c_q         <= '0;
      cout_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cout_q      <= cout_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.c         = c_q;
  assign bus.cout      = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_gate_half_adder_unit.sv
// tb_gate_half_adder_unit: directed and randomized checks of gate_half_adder_unit at WIDTH=1 and WIDTH=4.
// Revision: 1.0
`default_nettype none

module tb_gate_half_adder_unit;
  localparam int W = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  gate_half_adder_unit_if #(.WIDTH(1)) bus1 ();
  gate_half_adder_unit_if #(.WIDTH(W)) bus4 ();

  gate_half_adder_unit #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gate_half_adder_unit #(.WIDTH(W)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  always #5 clk = ~clk;

  // Reference: {s, c, cout} from plain arithmetic.
  function automatic logic [2*W:0] model4(input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    logic [W-1:0] s, c;
    logic co;
    int ai, bi, lim;
    if (!m) begin
      s  = a ^ b;
      c  = a & b;
      co = |c;
    end else begin
      s  = W'((int'(a) + int'(b)) % (1 << W));
      co = ((int'(a) + int'(b)) >= (1 << W));
      for (int k = 0; k < W; k++) begin
        lim  = 1 << (k + 1);
        ai   = int'(a) % lim;
        bi   = int'(b) % lim;
        c[k] = (ai + bi) >= lim;
      end
    end
    return {s, c, co};
  endfunction

  task automatic drive4(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, input logic r);
    bus4.in_valid  = v;
    bus4.a         = a;
    bus4.b         = b;
    bus4.mode      = m;
    bus4.out_ready = r;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive4(1'b0, '0, '0, 1'b0, 1'b1);
    bus1.in_valid = 1'b0; bus1.a = 1'b0; bus1.b = 1'b0; bus1.mode = 1'b0; bus1.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout, bus4.in_ready} !== {1'b0, {(2*W){1'b0}}, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_w4: got v=%b s=%b c=%b co=%b rdy=%b, need 0 0000 0000 0 1",
               bus4.out_valid, bus4.s, bus4.c, bus4.cout, bus4.in_ready);
    end
    n_cmp++;
    if ({bus1.out_valid, bus1.s, bus1.c, bus1.cout, bus1.in_ready} !== 5'b00001) begin
      n_err++;
      $display("FAIL reset_w1: got %b, need 00001",
               {bus1.out_valid, bus1.s, bus1.c, bus1.cout, bus1.in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // WIDTH=1: both modes must give the plain half-adder truth table.
  task automatic test_w1_truth;
    logic ea, eb;
    for (int m = 0; m < 2; m++) begin
      for (int k = 0; k < 4; k++) begin
        ea = (k >> 1) & 1;
        eb = k & 1;
        @(negedge clk);
        bus1.in_valid = 1'b1; bus1.a = ea; bus1.b = eb; bus1.mode = m[0]; bus1.out_ready = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({bus1.out_valid, bus1.s, bus1.c, bus1.cout} !== {1'b1, ea ^ eb, ea & eb, ea & eb}) begin
          n_err++;
          $display("FAIL w1_truth m=%0d a=%b b=%b: got v/s/c/co=%b, need %b", m, ea, eb,
                   {bus1.out_valid, bus1.s, bus1.c, bus1.cout}, {1'b1, ea ^ eb, ea & eb, ea & eb});
        end
      end
    end
    @(negedge clk);
    bus1.in_valid = 1'b0;
  endtask

  task automatic test_w4_vectors;
    logic [8:0] vin  [4] = '{9'b1011_0110_0, 9'b1011_0110_1, 9'b1111_0001_1, 9'b0000_0000_1};
    logic [8:0] vexp [4] = '{9'b1101_0010_1, 9'b0001_1110_1, 9'b0000_1111_1, 9'b0000_0000_0};
    logic [8:0] cur;
    for (int k = 0; k < 4; k++) begin
      cur = vin[k];
      @(negedge clk);
      drive4(1'b1, cur[8:5], cur[4:1], cur[0], 1'b1);
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== {1'b1, vexp[k]}) begin
        n_err++;
        $display("FAIL w4_vector%0d: got v/s/c/co=%b, need %b", k,
                 {bus4.out_valid, bus4.s, bus4.c, bus4.cout}, {1'b1, vexp[k]});
      end
    end
    @(negedge clk);
    drive4(1'b0, 4'hF, 4'hF, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== {1'b0, vexp[3]}) begin
      n_err++;
      $display("FAIL w4_consume_hold: got %b, need %b",
               {bus4.out_valid, bus4.s, bus4.c, bus4.cout}, {1'b0, vexp[3]});
    end
  endtask

  task automatic test_backpressure;
    logic [W-1:0] a, b;
    logic m;
    logic [2*W:0] held, nxt;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); m = 1'($urandom);
    held = model4(a, b, m);
    drive4(1'b1, a, b, m, 1'b1);
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive4(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'b0);
      #1;
      n_cmp++;
      if (bus4.in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL stall_in_ready cyc%0d: got %b, need 0", k, bus4.in_ready);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== {1'b1, held}) begin
        n_err++;
        $display("FAIL stall_hold cyc%0d: got %b, need %b", k,
                 {bus4.out_valid, bus4.s, bus4.c, bus4.cout}, {1'b1, held});
      end
    end
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); m = 1'($urandom);
    nxt = model4(a, b, m);
    drive4(1'b1, a, b, m, 1'b1);
    #1;
    n_cmp++;
    if (bus4.in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL release_in_ready: got %b, need 1", bus4.in_ready);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== {1'b1, nxt}) begin
      n_err++;
      $display("FAIL release_result: got %b, need %b",
               {bus4.out_valid, bus4.s, bus4.c, bus4.cout}, {1'b1, nxt});
    end
  endtask

  // Random traffic against a one-deep result queue.
  task automatic test_random;
    logic [2*W:0] q[$];
    logic [2*W:0] held, want;
    logic [W-1:0] a, b;
    logic v, m, r, acc;
    @(negedge clk);
    a = W'($urandom); b = W'($urandom); m = 1'($urandom);
    drive4(1'b1, a, b, m, 1'b1);
    @(posedge clk);
    q.push_back(model4(a, b, m));
    held = q[0];
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      v = 1'($urandom); a = W'($urandom); b = W'($urandom); m = 1'($urandom);
      r = ($urandom_range(0, 3) != 0);
      drive4(v, a, b, m, r);
      #1;
      acc = v && (q.size() == 0 || r);
      n_cmp++;
      if (bus4.in_ready !== (q.size() == 0 || r)) begin
        n_err++;
        $display("FAIL rand_in_ready it%0d: got %b, need %b", k, bus4.in_ready, (q.size() == 0 || r));
      end
      @(posedge clk);
      if (q.size() > 0 && r) held = q.pop_front();
      if (acc) q.push_back(model4(a, b, m));
      #1;
      want = (q.size() > 0) ? q[0] : held;
      n_cmp++;
      if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== {(q.size() > 0), want}) begin
        n_err++;
        $display("FAIL rand_out it%0d: got %b, need %b", k,
                 {bus4.out_valid, bus4.s, bus4.c, bus4.cout}, {(q.size() > 0), want});
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    @(negedge clk);
    drive4(1'b1, 4'b1011, 4'b0110, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    drive4(1'b0, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout} !== 10'b1_0001_1110_1) begin
      n_err++;
      $display("FAIL pre_reset_stall: got %b, need 1000111101",
               {bus4.out_valid, bus4.s, bus4.c, bus4.cout});
    end
    @(negedge clk);
    rst_n = 1'b0;
    drive4(1'b1, 4'hF, 4'hF, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    n_cmp++;
    if ({bus4.out_valid, bus4.s, bus4.c, bus4.cout, bus4.in_ready} !== 11'b0_0000_0000_0_1) begin
      n_err++;
      $display("FAIL reset_mid_stall: got v/s/c/co/rdy=%b, need 00000000001",
               {bus4.out_valid, bus4.s, bus4.c, bus4.cout, bus4.in_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
    drive4(1'b0, '0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_w1_truth();
    test_w4_vectors();
    test_backpressure();
    test_random();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, need completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/gate_half_adder_unit.md
Name: gate_half_adder_unit

Overview:
- Registered, handshaked arithmetic primitive built from the team's 2-input AND and XOR gate cells.
- Mode 0 is a bitwise half adder (sum = XOR, carry = AND per bit).
- Mode 1 chains per-bit half adders into a ripple-carry adder.
- Sits in datapaths as a small pipeline stage; WIDTH=1, mode 0 is the plain single-bit half adder.

Parameters:
- WIDTH, 1, operand/result bit width (legal 1..32).

Ports:
- clk  in  1  single system clock, all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  operands/mode valid this cycle.
- in_ready  out  1  unit can accept an operation this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- mode  in  1  0 = bitwise half add, 1 = ripple add.
- out_valid  out  1  result registers hold an unconsumed result.
- out_ready  in  1  downstream accepts result this cycle.
- s  out  WIDTH  sum result.
- c  out  WIDTH  per-bit carry result.
- cout  out  1  carry out of the MSB stage.

Behaviour:
- Reset: rst_n low at a rising edge clears out_valid, s, c and cout to 0. This applies mid-operation too: any held result is discarded.
- No combinational path from a/b to s/c/cout; all results are registered.
- in_ready = !out_valid || out_ready. This is combinational, with a single output register (no skid buffer).
- Accept: when in_valid && in_ready at a rising edge, the result of a/b/mode is loaded and out_valid = 1 on the next cycle. Latency is 1 cycle.
- Consume without new accept: out_valid && out_ready at an edge clears out_valid. s/c/cout keep their last values.
- Simultaneous consume and accept: the new result replaces the old one and out_valid stays 1, giving back-to-back throughput of 1 per cycle.
- Stall: out_valid && !out_ready holds s/c/cout stable, in_ready = 0, and inputs are ignored.
- Mode 0, per bit i:
  - s[i] = a[i] XOR b[i]
  - c[i] = a[i] AND b[i]
  - cout = OR of all c bits
- Mode 1, ripple of half-adder pairs, carry-in to bit 0 = 0:
  - Stage i: p = a[i]^b[i], g = a[i]&b[i]; s[i] = p ^ cin_i; c[i] = g | (p & cin_i); cin_(i+1) = c[i].
  - cout = c[WIDTH-1]; s equals (a+b) mod 2^WIDTH.
- WIDTH=1: mode 1 and mode 0 give identical s, c and cout.
- mode is sampled only on accept; changing it while stalled has no effect.
- Overflow is not flagged separately; cout is the unsigned carry.

Test Plan:
- WIDTH=1, mode 0, out_ready=1, apply a/b = 00, 01, 10, 11 one per cycle -> s/c = 0/0, 1/0, 1/0, 0/1, each 1 cycle after its accept; cout equals c.
- WIDTH=4, mode 0, a=1011, b=0110 -> s=1101, c=0010, cout=1.
- WIDTH=4, mode 1, a=1011, b=0110 -> s=0001, c=1110, cout=1.
- WIDTH=4, mode 1, a=1111, b=0001 -> s=0000, c=1111, cout=1. Then a=0000, b=0000 -> s=0000, c=0000, cout=0.
- Backpressure: accept one op, then hold out_ready=0 for 3 cycles while driving new inputs -> in_ready=0, outputs unchanged. Raise out_ready with in_valid=1 -> new result appears next cycle, out_valid stays 1.
- Reset mid-stall: rst_n=0 for one edge while out_valid=1 -> out_valid, s, c and cout all 0 next cycle, in_ready=1.
